// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: sized loads/stores with sign/zero extension, misalignment
// faulting and an optional power-on clear pass over the whole array.
module dmem_bytelane #(
  parameter int ADDR_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid,
  output logic        misalign,
  output logic        ready
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             misalign_q, misalign_d;
  logic [1:0]       lane_q, lane_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      rdata_q;

  logic [31:0]      mem [DEPTH];

  logic             fault;
  logic             rd_en;
  logic [3:0]       we;
  logic [31:0]      wdata;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic [31-ADDR_W:0] unused_addr_hi;

  assign unused_addr_hi = addr[31:ADDR_W];
  assign ridx           = addr[ADDR_W-1:2];

  // Store rules apply whenever MemWrite is high, even if MemRead is also high.
  always_comb begin
    fault = 1'b0;
    case (funct3[1:0])
      2'b00:   fault = MemWrite & funct3[2];
      2'b01:   fault = addr[0] | (MemWrite & funct3[2]);
      2'b10:   fault = (addr[1:0] != 2'b00) | funct3[2];
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ready_d    = ready_q;
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    lane_d     = lane_q;
    f3_d       = f3_q;
    we         = 4'b0000;
    wdata      = 32'h0000_0000;
    widx       = ridx;
    rd_en      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        we        = 4'b1111;
        widx      = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (MemRead | MemWrite) begin
          if (fault) begin
            misalign_d = 1'b1;
          end else if (MemWrite) begin
            case (funct3[1:0])
              2'b00: begin
                we    = 4'b0001 << addr[1:0];
                wdata = {4{din[7:0]}};
              end
              2'b01: begin
                we    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
              end
              default: begin
                we    = 4'b1111;
                wdata = din;
              end
            endcase
          end else begin
            rd_en   = 1'b1;
            valid_d = 1'b1;
            lane_d  = addr[1:0];
            f3_d    = funct3;
          end
        end
      end
    endcase
    if (rst) begin
      we    = 4'b0000;
      rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ready_q    <= !CLEAR_ON_RESET;
      clr_cnt_q  <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      lane_q     <= 2'b00;
      f3_q       <= 3'b000;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      clr_cnt_q  <= clr_cnt_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read register only loads on an accepted load, so dout holds between loads.
  always_ff @(posedge clk) begin
    if (rst)        rdata_q <= 32'h0000_0000;
    else if (rd_en) rdata_q <= mem[ridx];
  end

  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = rdata_q[8*lane_q +: 8];
    half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  dout = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  dout = {{16{half_sel[15]}}, half_sel};
      3'b100:  dout = {24'h000000, byte_sel};
      3'b101:  dout = {16'h0000, half_sel};
      default: dout = rdata_q;
    endcase
  end

  assign valid    = valid_q;
  assign misalign = misalign_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: byte-array reference model compared every cycle,
// plus directed loads/stores with literal expected values.
module tb_dmem_bytelane;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        valid;
  logic        misalign;
  logic        ready;

  int checks = 0;
  int failures = 0;

  dmem_bytelane #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .din(din),
    .dout(dout), .valid(valid), .misalign(misalign), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, clear as a countdown of words.
  logic [7:0]  m_mem [DEPTH*4];
  int          clr_left = DEPTH;
  bit          m_ready = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_dout = 32'h0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    int a, n;
    bit bad;
    logic [31:0] v;
    if (rst) begin
      clr_left = DEPTH;
      m_ready  = 1'b0;
      m_valid  = 1'b0;
      m_mis    = 1'b0;
      m_dout   = 32'h0;
    end else begin
      m_valid = 1'b0;
      m_mis   = 1'b0;
      if (clr_left > 0) begin
        for (int b = 0; b < 4; b++) m_mem[(DEPTH - clr_left) * 4 + b] = 8'h00;
        clr_left--;
        m_ready = (clr_left == 0);
      end else if (MemRead || MemWrite) begin
        a = int'(addr[ADDR_W-1:0]);
        n = 1 << funct3[1:0];
        if (MemWrite) bad = (funct3 > 3'd2);
        else          bad = (funct3 == 3'b011) || (funct3 >= 3'b110);
        if (!bad && (a % n) != 0) bad = 1'b1;
        if (bad) begin
          m_mis = 1'b1;
        end else if (MemWrite) begin
          for (int k = 0; k < n; k++) m_mem[a + k] = din[8*k +: 8];
        end else begin
          v = 32'h0;
          for (int k = 0; k < n; k++) v[8*k +: 8] = m_mem[a + k];
          if (!funct3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
          if (!funct3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
          m_dout  = v;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", {31'b0, ready}, {31'b0, m_ready});
      check("cyc_valid", {31'b0, valid}, {31'b0, m_valid});
      check("cyc_misalign", {31'b0, misalign}, {31'b0, m_mis});
      check("cyc_dout", dout, m_dout);
    end
  end

  // Present a request, let it be sampled, return 1 time unit after that edge.
  task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d);
    MemRead  = rd;
    MemWrite = wr;
    funct3   = f3;
    addr     = a;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 16);
  endtask

  task automatic load_exp(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] exp);
    op(1'b1, 1'b0, f3, a, 32'h0);
    check({name, "_valid"}, {31'b0, valid}, 32'd1);
    check(name, dout, exp);
  endtask

  task automatic fault_exp(input string name, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] keep);
    op(!wr, wr, f3, a, 32'hDEAD_BEEF);
    check({name, "_mis"}, {31'b0, misalign}, 32'd1);
    check({name, "_valid"}, {31'b0, valid}, 32'd0);
    check({name, "_dout"}, dout, keep);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t lv [9] = '{
    '{3'b000, 32'h8, 32'h0000_0001},
    '{3'b000, 32'h9, 32'h0000_007F},
    '{3'b000, 32'hA, 32'hFFFF_FFF1},
    '{3'b100, 32'hA, 32'h0000_00F1},
    '{3'b000, 32'hB, 32'hFFFF_FF80},
    '{3'b100, 32'hB, 32'h0000_0080},
    '{3'b001, 32'h8, 32'h0000_7F01},
    '{3'b001, 32'hA, 32'hFFFF_80F1},
    '{3'b101, 32'hA, 32'h0000_80F1}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle();
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_dout", dout, 32'h0);

    rst = 1'b0;
    wait_ready("clear_len");

    for (int w = 0; w < DEPTH; w++) load_exp("lw_cleared", 3'b010, 32'(w * 4), 32'h0);

    op(1'b0, 1'b1, 3'b010, 32'h8, 32'h80F1_7F01);
    for (int i = 0; i < 9; i++) load_exp("ld_ext", lv[i].f3, lv[i].a, lv[i].exp);

    op(1'b0, 1'b1, 3'b010, 32'h4, 32'h0);
    op(1'b0, 1'b1, 3'b000, 32'h5, 32'h0000_00AA);
    op(1'b0, 1'b1, 3'b001, 32'h6, 32'h0000_1234);
    load_exp("lanes_lw4", 3'b010, 32'h4, 32'h1234_AA00);
    load_exp("lanes_lw8", 3'b010, 32'h8, 32'h80F1_7F01);

    load_exp("pre_fault", 3'b010, 32'h4, 32'h1234_AA00);
    fault_exp("lh_at3", 1'b0, 3'b001, 32'h3, 32'h1234_AA00);
    fault_exp("lw_at6", 1'b0, 3'b010, 32'h6, 32'h1234_AA00);
    fault_exp("ld_f3_011", 1'b0, 3'b011, 32'h4, 32'h1234_AA00);
    fault_exp("ld_f3_110", 1'b0, 3'b110, 32'h4, 32'h1234_AA00);
    fault_exp("sw_at2", 1'b1, 3'b010, 32'h2, 32'h1234_AA00);
    fault_exp("sh_at1", 1'b1, 3'b001, 32'h1, 32'h1234_AA00);
    fault_exp("sb_f3_100", 1'b1, 3'b100, 32'h0, 32'h1234_AA00);
    load_exp("word0_kept", 3'b010, 32'h0, 32'h0);

    op(1'b0, 1'b1, 3'b010, 32'h10, 32'h1111_1111);
    load_exp("st_then_ld", 3'b010, 32'h10, 32'h1111_1111);
    op(1'b1, 1'b1, 3'b010, 32'h14, 32'h2222_2222);
    check("rdwr_no_valid", {31'b0, valid}, 32'd0);
    load_exp("rdwr_stored", 3'b010, 32'h14, 32'h2222_2222);
    load_exp("alias_hi", 3'b010, 32'hFFFF_FF54, 32'h2222_2222);

    rst = 1'b1;
    idle();
    rst = 1'b0;
    repeat (7) idle();
    check("mid_clear_ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    wait_ready("clear_restart");

    rst = 1'b1;
    op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("rst_load_valid", {31'b0, valid}, 32'd0);
    rst = 1'b0;
    wait_ready("clear_after_load");
    load_exp("recleared_10", 3'b010, 32'h10, 32'h0);
    load_exp("recleared_8", 3'b010, 32'h8, 32'h0);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised data memory for the single-cycle/pipelined CPU datapath, replacing the word-only data RAM. Supports RISC-V sized accesses with per-byte-lane writes (sb/sh/sw), sign- or zero-extended loads (lb/lh/lw/lbu/lhu), misalignment faulting, and an optional power-on clear sequence that zeroes the array before the core may access it. Sits between the ALU result/rs2 path and the write-back mux; the array is an inferred synchronous-read RAM, so no vendor IP is required.

## Interface
- ADDR_W, 16: byte-address bits used; depth = 2^(ADDR_W-2) 32-bit words; addr[31:ADDR_W] ignored (aliases).
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset before asserting ready; 0 = ready immediately, contents undefined.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRead  input  1  load request, sampled when ready=1.
- MemWrite  input  1  store request, sampled when ready=1.
- funct3  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010 only).
- addr  input  32  byte address.
- din  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dout  output  32  extended load data.
- valid  output  1  one-cycle pulse: dout carries a new load result.
- misalign  output  1  one-cycle pulse: the accepted access faulted.
- ready  output  1  block accepts requests this cycle.

## Operation
- States: CLEAR, RUN. rst (any state, any cycle) -> CLEAR with clear counter 0 if CLEAR_ON_RESET, else RUN; in-flight load discarded.
- CLEAR: writes 0 to word counter, counter+1 each cycle; on counter = depth-1 write, next state RUN. ready=0; MemRead/MemWrite ignored.
- RUN: ready=1; request accepted when MemRead or MemWrite high.
- Fault: funct3 in {011,110,111}, or halfword with addr[0]=1, or word with addr[1:0]!=0. Faulted access: no array write, no valid, misalign=1 next cycle, dout unchanged.
- Store lanes (word index addr[ADDR_W-1:2]): sb -> lane addr[1:0] gets din[7:0]; sh -> lanes {addr[1],0} and {addr[1],1} get din[15:0]; sw -> all lanes din. Other lanes untouched. funct3 100/101 on a store = fault.
- Load: reads full word, selects lane(s) by registered addr[1:0] and funct3, extends: lb/lh sign-extend bit 7/15, lbu/lhu zero-extend, lw pass-through.
- MemRead and MemWrite both high: store performed, load ignored (no valid); fault check uses store rules.
- dout holds last valid load result until the next valid load.

## Timing
- Reset values: dout=0, valid=0, misalign=0, ready=0 when CLEAR_ON_RESET=1 else 1.
- CLEAR lasts exactly 2^(ADDR_W-2) cycles after the first cycle rst is low; ready rises on the following cycle.
- Load latency 1: accepted at edge N, dout/valid valid after edge N+1 (valid high one cycle).
- Store completes at accepting edge; a load accepted the next cycle to the same word returns the new data (no stale read).
- misalign asserted one cycle after accept, same slot where valid would be.
- Back-to-back requests every cycle in RUN, no bubbles.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_W=6 -> ready=0 for 16 cycles, then 1; lw from every word returns 0x00000000 with valid pulse 1 cycle after each request.
- sw 0x80F17F01 @0x8; lb/lbu/lh/lhu @0x8,0x9,0xA,0xB -> 0x00000001, 0x0000007F, 0xFFFFFFF1, 0x000000F1, 0x00007F01, 0xFFFF80F1 (lh@0xA), lhu@0xA -> 0x000080F1.
- sw 0 @0x4, sb 0xAA @0x5, sh 0x1234 @0x6 -> lw @0x4 = 0x1234AA00; lanes outside each store unchanged.
- lh @0x3, lw @0x6, load funct3=011 -> misalign pulse each, valid=0, dout keeps previous value; sw @0x2 misaligned leaves word @0x0 unchanged.
- sw 0x11111111 @0x10 in cycle N, lw @0x10 in cycle N+1 -> dout=0x11111111 at N+2; MemRead&MemWrite same cycle -> store written, no valid.
- Assert rst during CLEAR (counter mid-way) and during an outstanding load -> valid never pulses, counter restarts at 0, full CLEAR length repeats.
